mux_rr_stage: RTL

Parametrised N:1 selector with a one-entry registered output stage and valid/ready handshakes on every input and on the output. It replaces plain combinational 2:1 data muxes wherever several pipeline sources compete for one downstream consumer, such as writeback or a shared bus port. A source is chosen either by an explicit select input or by round-robin arbitration. The output is registered, so the block also cuts the timing path between producers and the consumer.

---
 rtl/mux_rr_stage.sv | 116 +++++++++++
 1 files changed

// File: rtl/mux_rr_stage.sv
// N:1 valid/ready selector with a one-entry registered output stage.
// Define MUX_RR_EN to compile in the round-robin arbiter (sel_mode = 1); otherwise explicit select only.
module mux_rr_stage #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sel_mode,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_ch
);

    logic             ex_valid;
    logic [SEL_W-1:0] ex_idx;
    logic             gnt_valid;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             can_accept;
    logic             in_xfer;

    // Out-of-range sel never matches a channel, so it yields no grant.
    always_comb begin
        ex_valid = 1'b0;
        ex_idx   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) begin
                ex_valid = 1'b1;
                ex_idx   = SEL_W'(i);
            end
        end
    end

`ifdef MUX_RR_EN
    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;
    logic [SEL_W-1:0] last_ptr;

    always_comb begin
        logic [SEL_W-1:0] cand;
        rr_valid = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int unsigned k = 1; k <= NUM_IN; k++) begin
            cand = SEL_W'((32'(last_ptr) + k) % NUM_IN);
            if (!rr_valid && in_valid[cand]) begin
                rr_valid = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    always_comb begin
        if (sel_mode) begin
            gnt_valid = rr_valid;
            gnt_idx   = rr_idx;
        end else begin
            gnt_valid = ex_valid;
            gnt_idx   = ex_idx;
        end
    end

    // Pointer follows every input transfer, whatever mode produced it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ptr <= SEL_W'(NUM_IN - 1);
        end else if (in_xfer) begin
            last_ptr <= gnt_idx;
        end
    end
`else
    logic unused_sel_mode;
    assign unused_sel_mode = sel_mode;

    always_comb begin
        gnt_valid = ex_valid;
        gnt_idx   = ex_idx;
    end
`endif

    assign can_accept = !out_valid || out_ready;
    assign in_xfer    = rst_n && gnt_valid && can_accept;

    always_comb begin
        in_ready = '0;
        gnt_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                in_ready[i] = in_xfer;
                gnt_data    = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_ch    <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
